// File: rtl/axi_llc_partition_ctrl_if.sv
// Partition controller bus: table handshake, flush handshake,
// partition lookup and status. Slave = controller, master = driver.
interface axi_llc_partition_ctrl_if #(
  parameter int unsigned NumPart = 4,
  parameter int unsigned SW      = 5,
  parameter int unsigned IW      = 4,
  parameter int unsigned PW      = 2
);
  logic                  cfg_valid_i;
  logic                  cfg_ready_o;
  logic [NumPart*SW-1:0] cfg_size_i;
  logic                  flush_req_o;
  logic                  flush_ack_i;
  logic [PW-1:0]         part_id_i;
  logic [SW-1:0]         pat_size_o;
  logic [IW-1:0]         start_index_o;
  logic [SW-1:0]         share_size_o;
  logic [IW-1:0]         share_index_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;

  modport slave (
    input  cfg_valid_i, cfg_size_i,
    input  flush_ack_i, part_id_i,
    output cfg_ready_o, flush_req_o,
    output pat_size_o, start_index_o,
    output share_size_o, share_index_o,
    output busy_o, done_o, err_o
  );

  modport master (
    output cfg_valid_i, cfg_size_i,
    output flush_ack_i, part_id_i,
    input  cfg_ready_o, flush_req_o,
    input  pat_size_o, start_index_o,
    input  share_size_o, share_index_o,
    input  busy_o, done_o, err_o
  );
endinterface

// File: rtl/axi_llc_partition_ctrl.sv
// LLC set-partition controller: computes partition start indices from a
// size table, checks it fits, flushes the LLC, then commits atomically.
// Ports: clk_i, rst_i (async, active-high), bus (slave modport).
package axi_llc_pkg;
  typedef struct packed {
    int unsigned SetAssociativity;
    int unsigned NumLines;
    int unsigned NumBlocks;
    int unsigned IndexLength;
  } llc_cfg_t;
endpackage

module axi_llc_partition_ctrl
  import axi_llc_pkg::*;
#(
  parameter llc_cfg_t    Cfg     = llc_cfg_t'{default: '0},
  parameter int unsigned NumPart = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  axi_llc_partition_ctrl_if.slave bus
);
  // Degenerate zero-length index is widened to keep vectors non-empty.
  localparam int unsigned IW =
    (Cfg.IndexLength < 1) ? 1 : Cfg.IndexLength;
  localparam int unsigned SW = IW + 1;
  localparam int unsigned PW =
    (NumPart > 1) ? $clog2(NumPart) : 1;
  localparam int unsigned AW = SW + PW;
  localparam logic [AW-1:0] NSETS = AW'(2 ** IW);

  typedef enum logic [2:0] {
    IDLE, CALC, CHECK, FLUSH, COMMIT
  } state_t;

  state_t r_state, w_next;

  logic [PW-1:0] r_ptr;
  logic [AW-1:0] r_acc;
  logic [SW-1:0] r_sh_size  [NumPart];
  logic [IW-1:0] r_sh_start [NumPart];
  logic [IW-1:0] r_sh_sidx;
  logic [SW-1:0] r_sh_ssz;
  logic [SW-1:0] r_size  [NumPart];
  logic [IW-1:0] r_start [NumPart];
  logic [IW-1:0] r_sidx;
  logic [SW-1:0] r_ssz;

  logic [SW-1:0] w_cur_size;
  logic          w_over;
  logic          w_last;

  assign w_over = (r_acc >= NSETS);
  assign w_last = (r_ptr == PW'(NumPart - 1));

  always_comb begin
    w_cur_size = '0;
    for (int p = 0; p < NumPart; p++)
      if (r_ptr == PW'(p)) w_cur_size = r_sh_size[p];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    bus.cfg_ready_o = 1'b0;
    bus.busy_o      = 1'b1;
    bus.flush_req_o = 1'b0;
    bus.done_o      = 1'b0;
    bus.err_o       = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.cfg_ready_o = 1'b1;
        bus.busy_o      = 1'b0;
        if (bus.cfg_valid_i) w_next = CALC;
      end
      CALC: begin
        if (w_last) w_next = CHECK;
      end
      CHECK: begin
        bus.err_o = w_over;
        w_next    = w_over ? IDLE : FLUSH;
      end
      FLUSH: begin
        bus.flush_req_o = 1'b1;
        if (bus.flush_ack_i) w_next = COMMIT;
      end
      COMMIT: begin
        bus.done_o = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr     <= '0;
      r_acc     <= '0;
      r_sh_sidx <= '0;
      r_sh_ssz  <= SW'(NSETS);
      r_sidx    <= '0;
      r_ssz     <= SW'(NSETS);
      for (int p = 0; p < NumPart; p++) begin
        r_sh_size[p]  <= '0;
        r_sh_start[p] <= '0;
        r_size[p]     <= '0;
        r_start[p]    <= '0;
      end
    end else begin
      if (r_state == IDLE && bus.cfg_valid_i) begin
        r_ptr <= '0;
        r_acc <= '0;
        for (int p = 0; p < NumPart; p++)
          r_sh_size[p] <= bus.cfg_size_i[p*SW +: SW];
      end
      if (r_state == CALC) begin
        for (int p = 0; p < NumPart; p++)
          if (r_ptr == PW'(p)) r_sh_start[p] <= r_acc[IW-1:0];
        r_acc <= r_acc + AW'(w_cur_size);
        r_ptr <= r_ptr + 1'b1;
      end
      // Remainder of the set space goes to the shared region; the
      // range check guarantees it is at least one set.
      if (r_state == CHECK && !w_over) begin
        r_sh_sidx <= r_acc[IW-1:0];
        r_sh_ssz  <= SW'(NSETS - r_acc);
      end
      if (r_state == COMMIT) begin
        r_sidx <= r_sh_sidx;
        r_ssz  <= r_sh_ssz;
        for (int p = 0; p < NumPart; p++) begin
          r_size[p]  <= r_sh_size[p];
          r_start[p] <= r_sh_start[p];
        end
      end
    end
  end

  // Out-of-range ids fall through to zero.
  always_comb begin
    bus.pat_size_o    = '0;
    bus.start_index_o = '0;
    for (int p = 0; p < NumPart; p++) begin
      if (bus.part_id_i == PW'(p)) begin
        bus.pat_size_o    = r_size[p];
        bus.start_index_o = r_start[p];
      end
    end
  end

  assign bus.share_size_o  = r_ssz;
  assign bus.share_index_o = r_sidx;

endmodule

// File: tb/tb_axi_llc_partition_ctrl.sv
// Directed bench for axi_llc_partition_ctrl (16 sets, 4 and 3
// partitions): reset, commit, reject, ignore, reset-in-flush, lookup.
module tb_axi_llc_partition_ctrl;
  import axi_llc_pkg::*;

  localparam llc_cfg_t CFG =
    llc_cfg_t'{IndexLength: 32'd4, default: '0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_llc_partition_ctrl_if #(
    .NumPart(4), .SW(5), .IW(4), .PW(2)) b4();
  axi_llc_partition_ctrl_if #(
    .NumPart(3), .SW(5), .IW(4), .PW(2)) b3();

  axi_llc_partition_ctrl #(.Cfg(CFG), .NumPart(4)) dut (
    .clk_i(clk), .rst_i(rst), .bus(b4.slave));
  axi_llc_partition_ctrl #(.Cfg(CFG), .NumPart(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .bus(b3.slave));

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [19:0] pack4(
    int s0, int s1, int s2, int s3);
    return {5'(s3), 5'(s2), 5'(s1), 5'(s0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b4.cfg_valid_i = 1'b0;
    b4.cfg_size_i  = '0;
    b4.flush_ack_i = 1'b0;
    b4.part_id_i   = '0;
    b3.cfg_valid_i = 1'b0;
    b3.cfg_size_i  = '0;
    b3.flush_ack_i = 1'b1;
    b3.part_id_i   = '0;
    repeat (2) step();
    rst = 1'b0;
    step();
    n_total++;
    if (b4.share_size_o !== 5'd16)
      $display("FAIL rst_share_size: got %0d want 16",
               b4.share_size_o);
    else n_pass++;
    n_total++;
    if (b4.share_index_o !== 4'd0)
      $display("FAIL rst_share_index: got %0d want 0",
               b4.share_index_o);
    else n_pass++;
    n_total++;
    if (b4.cfg_ready_o !== 1'b1 || b4.busy_o !== 1'b0)
      $display("FAIL rst_ready_busy: got %b%b want 10",
               b4.cfg_ready_o, b4.busy_o);
    else n_pass++;
    n_total++;
    if ({b4.flush_req_o, b4.done_o, b4.err_o} !== 3'b000)
      $display("FAIL rst_flush_done_err: got %b%b%b want 000",
               b4.flush_req_o, b4.done_o, b4.err_o);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      b4.part_id_i = 2'(i);
      #1;
      n_total++;
      if (b4.pat_size_o !== 5'd0 || b4.start_index_o !== 4'd0)
        $display("FAIL rst_part%0d: got %0d/%0d want 0/0", i,
                 b4.pat_size_o, b4.start_index_o);
      else n_pass++;
    end
  endtask

  task automatic test_commit();
    int es [4] = '{4, 2, 0, 3};
    int est[4] = '{0, 4, 6, 6};
    b4.cfg_size_i  = pack4(4, 2, 0, 3);
    b4.cfg_valid_i = 1'b1;
    #1;
    n_total++;
    if (b4.cfg_ready_o !== 1'b1)
      $display("FAIL commit_ready_c0: got %b want 1",
               b4.cfg_ready_o);
    else n_pass++;
    step();
    b4.cfg_valid_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      n_total++;
      if (b4.flush_req_o !== 1'b0 || b4.busy_o !== 1'b1)
        $display("FAIL commit_calc_c%0d: got flush=%b busy=%b want 0 1",
                 c, b4.flush_req_o, b4.busy_o);
      else n_pass++;
      step();
    end
    for (int c = 6; c <= 8; c++) begin
      n_total++;
      if (b4.flush_req_o !== 1'b1)
        $display("FAIL commit_flush_c%0d: got %b want 1",
                 c, b4.flush_req_o);
      else n_pass++;
      if (c == 8) b4.flush_ack_i = 1'b1;
      step();
    end
    b4.flush_ack_i = 1'b0;
    n_total++;
    if (b4.done_o !== 1'b1 || b4.flush_req_o !== 1'b0)
      $display("FAIL commit_done_c9: got done=%b flush=%b want 1 0",
               b4.done_o, b4.flush_req_o);
    else n_pass++;
    n_total++;
    if (b4.share_size_o !== 5'd16)
      $display("FAIL commit_not_early: got %0d want 16",
               b4.share_size_o);
    else n_pass++;
    step();
    n_total++;
    if (b4.done_o !== 1'b0 || b4.busy_o !== 1'b0)
      $display("FAIL commit_idle_c10: got done=%b busy=%b want 0 0",
               b4.done_o, b4.busy_o);
    else n_pass++;
    n_total++;
    if (b4.share_index_o !== 4'd9 || b4.share_size_o !== 5'd7)
      $display("FAIL commit_share: got %0d/%0d want 9/7",
               b4.share_index_o, b4.share_size_o);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      b4.part_id_i = 2'(i);
      #1;
      n_total++;
      if (b4.pat_size_o !== 5'(es[i]) ||
          b4.start_index_o !== 4'(est[i]))
        $display("FAIL commit_part%0d: got %0d/%0d want %0d/%0d", i,
                 b4.pat_size_o, b4.start_index_o, es[i], est[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reject();
    b4.cfg_size_i  = pack4(8, 8, 0, 0);
    b4.cfg_valid_i = 1'b1;
    step();
    b4.cfg_valid_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_total++;
      if (b4.err_o !== 1'b0)
        $display("FAIL reject_early_err_c%0d: got %b want 0",
                 c, b4.err_o);
      else n_pass++;
      step();
    end
    n_total++;
    if (b4.err_o !== 1'b1 || b4.flush_req_o !== 1'b0)
      $display("FAIL reject_c5: got err=%b flush=%b want 1 0",
               b4.err_o, b4.flush_req_o);
    else n_pass++;
    step();
    n_total++;
    if (b4.err_o !== 1'b0 || b4.cfg_ready_o !== 1'b1 ||
        b4.busy_o !== 1'b0 || b4.flush_req_o !== 1'b0)
      $display("FAIL reject_c6: got err=%b rdy=%b busy=%b fl=%b want 0100",
               b4.err_o, b4.cfg_ready_o, b4.busy_o, b4.flush_req_o);
    else n_pass++;
    b4.part_id_i = 2'd1;
    #1;
    n_total++;
    if (b4.share_index_o !== 4'd9 || b4.share_size_o !== 5'd7 ||
        b4.pat_size_o !== 5'd2 || b4.start_index_o !== 4'd4)
      $display("FAIL reject_unchanged: got %0d/%0d %0d/%0d want 9/7 2/4",
               b4.share_index_o, b4.share_size_o,
               b4.pat_size_o, b4.start_index_o);
    else n_pass++;
  endtask

  task automatic test_ignore();
    b4.cfg_size_i  = pack4(1, 2, 3, 9);
    b4.cfg_valid_i = 1'b1;
    step();
    b4.cfg_size_i = pack4(15, 15, 15, 15);
    for (int c = 1; c <= 5; c++) begin
      b4.flush_ack_i = (c == 2);
      #1;
      n_total++;
      if (b4.cfg_ready_o !== 1'b0)
        $display("FAIL ignore_ready_c%0d: got %b want 0",
                 c, b4.cfg_ready_o);
      else n_pass++;
      step();
    end
    b4.flush_ack_i = 1'b0;
    for (int c = 6; c <= 8; c++) begin
      n_total++;
      if (b4.flush_req_o !== 1'b1 || b4.cfg_ready_o !== 1'b0)
        $display("FAIL ignore_flush_c%0d: got fl=%b rdy=%b want 1 0",
                 c, b4.flush_req_o, b4.cfg_ready_o);
      else n_pass++;
      if (c == 8) begin
        b4.flush_ack_i = 1'b1;
        b4.cfg_valid_i = 1'b0;
      end
      step();
    end
    b4.flush_ack_i = 1'b0;
    n_total++;
    if (b4.done_o !== 1'b1)
      $display("FAIL ignore_done_c9: got %b want 1", b4.done_o);
    else n_pass++;
    step();
    n_total++;
    if (b4.share_index_o !== 4'd15 || b4.share_size_o !== 5'd1)
      $display("FAIL ignore_share_min: got %0d/%0d want 15/1",
               b4.share_index_o, b4.share_size_o);
    else n_pass++;
    b4.part_id_i = 2'd3;
    #1;
    n_total++;
    if (b4.pat_size_o !== 5'd9 || b4.start_index_o !== 4'd6)
      $display("FAIL ignore_part3: got %0d/%0d want 9/6",
               b4.pat_size_o, b4.start_index_o);
    else n_pass++;
  endtask

  task automatic test_reset_in_flush();
    b4.cfg_size_i  = pack4(2, 2, 2, 2);
    b4.cfg_valid_i = 1'b1;
    step();
    b4.cfg_valid_i = 1'b0;
    repeat (5) step();
    n_total++;
    if (b4.flush_req_o !== 1'b1)
      $display("FAIL rif_flush_before: got %b want 1",
               b4.flush_req_o);
    else n_pass++;
    b4.part_id_i = 2'd3;
    rst = 1'b1;
    #1;
    n_total++;
    if (b4.flush_req_o !== 1'b0 || b4.busy_o !== 1'b0 ||
        b4.cfg_ready_o !== 1'b1)
      $display("FAIL rif_abort: got fl=%b busy=%b rdy=%b want 0 0 1",
               b4.flush_req_o, b4.busy_o, b4.cfg_ready_o);
    else n_pass++;
    n_total++;
    if (b4.share_size_o !== 5'd16 || b4.share_index_o !== 4'd0 ||
        b4.pat_size_o !== 5'd0 || b4.start_index_o !== 4'd0)
      $display("FAIL rif_defaults: got %0d/%0d %0d/%0d want 16/0 0/0",
               b4.share_size_o, b4.share_index_o,
               b4.pat_size_o, b4.start_index_o);
    else n_pass++;
    step();
    rst = 1'b0;
    step();
    test_commit();
  endtask

  task automatic test_lookup();
    b4.part_id_i = 2'd3;
    #1;
    n_total++;
    if (b4.pat_size_o !== 5'd3 || b4.start_index_o !== 4'd6)
      $display("FAIL lookup_id3: got %0d/%0d want 3/6",
               b4.pat_size_o, b4.start_index_o);
    else n_pass++;
    b3.cfg_size_i  = {5'd3, 5'd2, 5'd4};
    b3.cfg_valid_i = 1'b1;
    step();
    b3.cfg_valid_i = 1'b0;
    repeat (7) step();
    b3.part_id_i = 2'd3;
    #1;
    n_total++;
    if (b3.pat_size_o !== 5'd0 || b3.start_index_o !== 4'd0)
      $display("FAIL np3_id3: got %0d/%0d want 0/0",
               b3.pat_size_o, b3.start_index_o);
    else n_pass++;
    b3.part_id_i = 2'd2;
    #1;
    n_total++;
    if (b3.pat_size_o !== 5'd3 || b3.start_index_o !== 4'd6)
      $display("FAIL np3_id2: got %0d/%0d want 3/6",
               b3.pat_size_o, b3.start_index_o);
    else n_pass++;
    n_total++;
    if (b3.share_index_o !== 4'd9 || b3.share_size_o !== 5'd7)
      $display("FAIL np3_share: got %0d/%0d want 9/7",
               b3.share_index_o, b3.share_size_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_commit();
    test_reject();
    test_ignore();
    test_reset_in_flush();
    test_lookup();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_llc_partition_ctrl.md
AXI_LLC_PARTITION_CTRL -- requirements
Module: axi_llc_partition_ctrl

Interface
REQ-001 SHALL have parameter Cfg, default axi_llc_pkg::llc_cfg_t'{default: '0}, LLC static configuration; only Cfg.IndexLength is used, and NumSets = 2**Cfg.IndexLength.
REQ-002 SHALL have parameter NumPart, default 4, number of partitions, >= 1.
REQ-003 SHALL use size width SW = Cfg.IndexLength+1, index width IW = Cfg.IndexLength, id width PW = max(1, clog2(NumPart)).
REQ-004 clk_i  input  1  clock, rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 cfg_valid_i  input  1  new partition table offered.
REQ-007 cfg_ready_o  output  1  table accepted when valid&&ready.
REQ-008 cfg_size_i  input  NumPart*SW  requested set count per partition; partition p occupies bits [p*SW +: SW].
REQ-009 flush_req_o  output  1  request to drain/flush the LLC before remap.
REQ-010 flush_ack_i  input  1  flush complete.
REQ-011 part_id_i  input  PW  partition lookup select.
REQ-012 pat_size_o  output  SW  active size of partition part_id_i.
REQ-013 start_index_o  output  IW  active start index of partition part_id_i.
REQ-014 share_size_o  output  SW  active shared-region size.
REQ-015 share_index_o  output  IW  active shared-region start index.
REQ-016 busy_o  output  1  high when the FSM is in any state other than IDLE.
REQ-017 done_o  output  1  one-cycle pulse on commit.
REQ-018 err_o  output  1  one-cycle pulse on rejected table.

Function
REQ-019 SHALL implement FSM states IDLE, CALC, CHECK, FLUSH, COMMIT.
REQ-020 IDLE: cfg_ready_o=1; on cfg_valid_i, latch cfg_size_i into shadow sizes, clear acc and ptr, go to CALC. In all other states cfg_ready_o=0, and cfg_valid_i SHALL be ignored.
REQ-021 CALC: one partition per cycle: shadow_start[ptr]=acc[IW-1:0]; acc+=shadow_size[ptr]; ptr++. After ptr==NumPart-1, go to CHECK (CALC lasts exactly NumPart cycles).
REQ-022 acc SHALL be SW+PW bits wide; the sum SHALL never wrap.
REQ-023 CHECK: if acc >= NumSets, pulse err_o, return to IDLE, leave active registers unchanged, and do not assert flush_req_o. Otherwise set shadow share_index=acc, shadow share_size=NumSets-acc, and go to FLUSH.
REQ-024 FLUSH: flush_req_o=1 (registered, asserted from the first FLUSH cycle) and held until flush_ack_i is sampled high; then go to COMMIT. flush_ack_i SHALL be ignored outside FLUSH.
REQ-025 COMMIT: flush_req_o=0 and done_o=1; all shadow sizes, starts and share values are copied to the active registers atomically on the clock edge ending COMMIT; next state is IDLE.
REQ-026 Latency: handshake at cycle 0 -> CALC cycles 1..NumPart -> CHECK cycle NumPart+1 -> flush_req_o high from cycle NumPart+2 -> ack at cycle k -> done_o at cycle k+1 -> new active values visible at cycle k+2.
REQ-027 Lookup outputs SHALL be combinational from active registers and part_id_i; part_id_i >= NumPart SHALL return pat_size_o=0 and start_index_o=0.
REQ-028 Active share_size SHALL always be >= 1, so downstream modulo by share size is never by zero.
REQ-029 Zero-size partitions are legal; a zero-size partition's start equals the following partition's start.

Reset
REQ-030 rst_i SHALL asynchronously force: state=IDLE; cfg_ready_o=1; flush_req_o=0; done_o=0; err_o=0; busy_o=0; all active and shadow pat sizes and starts=0; active share_index=0; active share_size=NumSets; acc=0; ptr=0.
REQ-031 Reset asserted mid-operation (any state) SHALL abort the update, drop flush_req_o immediately, and discard the shadow table.

Verification (IndexLength=4 so NumSets=16, NumPart=4)
REQ-032 Release reset -> share_size_o=16, share_index_o=0, pat_size_o=0 for all ids, cfg_ready_o=1, busy_o=0.
REQ-033 Sizes {4,2,0,3} at cycle 0, ack at cycle 8 -> flush_req_o high cycles 6..8, done_o at cycle 9; from cycle 10 starts {0,4,6,6}, sizes {4,2,0,3}, share_index_o=9, share_size_o=7.
REQ-034 Sizes {8,8,0,0} (sum 16) -> err_o pulse at cycle 5, no flush_req_o, active values unchanged, back in IDLE with cfg_ready_o=1 at cycle 6.
REQ-035 cfg_valid_i with a new table held during CALC/FLUSH -> cfg_ready_o=0 and the table is not latched; flush_ack_i high during CALC -> no effect.
REQ-036 rst_i asserted while in FLUSH -> flush_req_o=0 in the same cycle, active values at reset defaults, and a subsequent table is accepted normally.
REQ-037 part_id_i=3 after REQ-033 -> pat_size_o=3, start_index_o=6; with NumPart=3, part_id_i=3 -> pat_size_o=0, start_index_o=0.
